// File: rtl/alu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_seq
// Purpose  : Execute-stage sequencer. Accepts one instruction at a time over
//            a valid/ready handshake, reads operands from an internal 8x16
//            register file, drives an external combinational ALU, writes the
//            result back and latches the returned n/z/p flags. Conditional
//            branches are evaluated against that condition register.
// Ports    : clk, rst_n              - clock, async active-low reset
//            instr_valid/ready       - instruction handshake
//            instr, pc               - instruction word and its address
//            alu_op, alu_a, alu_b    - ALU operation and operands (out)
//            alu_res, alu_n/z/p      - ALU result and flags (in)
//            done                    - one-cycle completion pulse
//            br_taken, br_target     - branch outcome, valid with done
//            illegal                 - unsupported opcode, valid with done
//            cond_nzp                - condition register {n,z,p}
//            dbg_addr, dbg_data      - combinational register-file read port
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_seq #(
    parameter int         NREG    = 8,
    parameter logic [3:0] HOLD_OP = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic [15:0] pc,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_res,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_p,
    output logic        done,
    output logic        br_taken,
    output logic [15:0] br_target,
    output logic        illegal,
    output logic [2:0]  cond_nzp,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] C_OP_LAST_ALU = 4'd8;
    localparam logic [3:0] C_OP_BR       = 4'd9;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_instr;
    logic [15:0] r_pc;
    logic [15:0] r_regs [NREG];
    logic [2:0]  r_cond;
    logic [3:0]  r_alu_op;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic        r_br_taken;
    logic [15:0] r_br_target;
    logic        r_illegal;

    // Field decode of the latched instruction word.
    logic [3:0]  w_opcode;
    logic [2:0]  w_dr;
    logic [2:0]  w_sr1;
    logic [2:0]  w_sr2;
    logic        w_imm;
    logic [15:0] w_imm_sext;
    logic [15:0] w_off_sext;
    logic        w_is_alu;
    logic        w_is_br;
    logic        w_accept;

    assign w_opcode   = r_instr[15:12];
    assign w_dr       = r_instr[11:9];
    assign w_sr1      = r_instr[8:6];
    assign w_sr2      = r_instr[2:0];
    assign w_imm      = r_instr[5];
    assign w_imm_sext = {{11{r_instr[4]}}, r_instr[4:0]};
    assign w_off_sext = {{7{r_instr[8]}}, r_instr[8:0]};
    assign w_is_alu   = (w_opcode <= C_OP_LAST_ALU);
    assign w_is_br    = (w_opcode == C_OP_BR);

    assign instr_ready = (r_state == S_IDLE);
    assign w_accept    = instr_valid && instr_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Branches and illegal opcodes need no ALU cycle,
    // so they skip EXEC and finish one cycle earlier.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_DECODE;
            S_DECODE: w_next = w_is_alu ? S_EXEC : S_DONE;
            S_EXEC:   w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Operands are registered at the end of DECODE so the ALU
    // sees stable inputs for the whole EXEC cycle; the write-back happens
    // at the closing edge of EXEC, which is also why SR1==DR / SR2==DR
    // read the old register value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr     <= '0;
            r_pc        <= '0;
            r_cond      <= 3'b010;
            r_alu_op    <= HOLD_OP;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_illegal   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_instr <= instr;
                        r_pc    <= pc;
                    end
                end
                S_DECODE: begin
                    if (w_is_alu) begin
                        r_alu_a  <= r_regs[w_sr1];
                        r_alu_b  <= w_imm ? w_imm_sext : r_regs[w_sr2];
                        r_alu_op <= w_opcode;
                    end else if (w_is_br) begin
                        // A zero mask can never intersect the condition code.
                        r_br_taken  <= |(w_dr & r_cond);
                        r_br_target <= r_pc + w_off_sext;
                    end else begin
                        r_illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_regs[w_dr] <= alu_res;
                    r_cond       <= {alu_n, alu_z, alu_p};
                    r_alu_op     <= HOLD_OP;
                end
                S_DONE: begin
                    r_br_taken <= 1'b0;
                    r_illegal  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign done      = (r_state == S_DONE);
    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign br_taken  = r_br_taken;
    assign br_target = r_br_target;
    assign illegal   = r_illegal;
    assign cond_nzp  = r_cond;
    assign dbg_data  = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_seq
// Purpose  : Self-checking bench for alu_issue_seq. Plays the role of the
//            combinational ALU and keeps an instruction-level reference model
//            (register array, condition code, last branch target).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [15:0] pc = '0;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_res = '0;
    logic        alu_n = 1'b0;
    logic        alu_z = 1'b1;
    logic        alu_p = 1'b0;
    logic        done;
    logic        br_taken;
    logic [15:0] br_target;
    logic        illegal;
    logic [2:0]  cond_nzp;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_accepts = 0;

    // Reference model state
    logic [15:0] m_regs [8];
    logic [2:0]  m_cond;
    logic [15:0] m_target;

    alu_issue_seq dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc(pc),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_n(alu_n), .alu_z(alu_z), .alu_p(alu_p),
        .done(done), .br_taken(br_taken), .br_target(br_target),
        .illegal(illegal), .cond_nzp(cond_nzp),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && instr_valid && instr_ready) n_accepts++;
    end

    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return ~a;
            4'd2: return a - b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return a * b;
            4'd7: return a << 1;
            4'd8: return a >> 1;
            default: return 16'h0000;
        endcase
    endfunction

    // Combinational ALU; holds result and flags while HOLD_OP is applied.
    always @(alu_op or alu_a or alu_b) begin
        if (alu_op != 4'hF) begin
            alu_res = alu_fn(alu_op, alu_a, alu_b);
            alu_n   = alu_res[15];
            alu_z   = (alu_res == 16'h0);
            alu_p   = !alu_res[15] && (alu_res != 16'h0);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_cond   = 3'b010;
        m_target = '0;
    endtask

    // Instruction-level reference: returns expected observables, updates state.
    task automatic ref_step(input logic [15:0] ins, input logic [15:0] p,
                            output int lat, output logic tk, output logic [15:0] tg,
                            output logic il, output logic [15:0] a, output logic [15:0] b,
                            output logic [3:0] op, output logic [2:0] cond, output logic [15:0] dv);
        logic [3:0]  opc;
        logic [15:0] r;
        opc = ins[15:12];
        tk = 1'b0; il = 1'b0; a = '0; b = '0; op = 4'hF;
        if (opc <= 4'd8) begin
            a = m_regs[ins[8:6]];
            b = ins[5] ? {{11{ins[4]}}, ins[4:0]} : m_regs[ins[2:0]];
            r = alu_fn(opc, a, b);
            m_regs[ins[11:9]] = r;
            m_cond = {r[15], r == 16'h0, !r[15] && r != 16'h0};
            lat = 3;
            op  = opc;
        end else if (opc == 4'd9) begin
            tk = (ins[11:9] & m_cond) != 3'b000;
            m_target = p + {{7{ins[8]}}, ins[8:0]};
            lat = 2;
        end else begin
            il  = 1'b1;
            lat = 2;
        end
        tg   = m_target;
        cond = m_cond;
        dv   = m_regs[ins[11:9]];
    endtask

    // Drives one handshake and records what the DUT shows; no checking here.
    task automatic run_instr(input logic [15:0] ins, input logic [15:0] p, input bit hold,
                             output int lat, output logic tk, output logic [15:0] tg,
                             output logic il, output logic [15:0] oa, output logic [15:0] ob,
                             output logic [3:0] oo, output logic [2:0] oc, output logic [15:0] od,
                             output logic d2, output logic r2);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        instr = ins; pc = p; instr_valid = 1'b1; dbg_addr = ins[11:9];
        @(posedge clk);
        #1;
        if (!hold) begin
            // Anything presented outside IDLE must be ignored.
            instr_valid = 1'b0;
            instr = 16'($urandom);
            pc    = 16'($urandom);
        end
        lat = -1; tk = 1'b0; tg = '0; il = 1'b0; oa = '0; ob = '0; oo = '0; oc = '0; od = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) begin
                oa = alu_a; ob = alu_b; oo = alu_op;
            end
            if (done) begin
                lat = c; tk = br_taken; tg = br_target; il = illegal; oc = cond_nzp; od = dbg_data;
                break;
            end
        end
        instr_valid = 1'b0;
        @(negedge clk);
        d2 = done;
        r2 = instr_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (alu_op !== 4'hF) begin n_fail++; $display("FAIL reset_alu_op: got %h expected f", alu_op); end
        n_tests++; if (cond_nzp !== 3'b010) begin n_fail++; $display("FAIL reset_cond: got %b expected 010", cond_nzp); end
        n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        n_tests++; if ({done, br_taken, illegal} !== 3'b000 || br_target !== 16'h0 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
            n_fail++; $display("FAIL reset_outputs: got done/bt/il=%b tgt=%h a=%h b=%h expected all zero",
                               {done, br_taken, illegal}, br_target, alu_a, alu_b);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            n_tests++; if (dbg_data !== 16'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0000", i, dbg_data); end
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_tests++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b expected 1", instr_ready); end
    endtask

    task automatic test_add_imm();
        int lat, elat; logic tk, etk, il, eil, d2, r2;
        logic [15:0] tg, etg, oa, ea, ob, eb, od, edv; logic [3:0] oo, eop; logic [2:0] oc, ec;
        // ADD R1, R0, #-3
        ref_step(16'h023D, 16'h0100, elat, etk, etg, eil, ea, eb, eop, ec, edv);
        run_instr(16'h023D, 16'h0100, 1'b0, lat, tk, tg, il, oa, ob, oo, oc, od, d2, r2);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", lat); end
        n_tests++; if (od !== 16'hFFFD) begin n_fail++; $display("FAIL add_r1: got %h expected fffd", od); end
        n_tests++; if (oc !== 3'b100) begin n_fail++; $display("FAIL add_cond: got %b expected 100", oc); end
        n_tests++; if (oa !== 16'h0 || ob !== 16'hFFFD || oo !== 4'h0) begin
            n_fail++; $display("FAIL add_exec_operands: got op=%h a=%h b=%h expected op=0 a=0000 b=fffd", oo, oa, ob);
        end
        n_tests++; if (d2 !== 1'b0 || r2 !== 1'b1) begin n_fail++; $display("FAIL add_done_pulse: got done=%b ready=%b expected 0 1", d2, r2); end
    endtask

    task automatic test_sub_branch_mul();
        int lat, elat; logic tk, etk, il, eil, d2, r2;
        logic [15:0] tg, etg, oa, ea, ob, eb, od, edv; logic [3:0] oo, eop; logic [2:0] oc, ec;
        logic [15:0] seq [6];
        seq = '{16'h0425, 16'h0625, 16'h2883, 16'h95FF, 16'h9BFF, 16'h6A83};
        for (int i = 0; i < 6; i++) begin
            ref_step(seq[i], 16'h3000, elat, etk, etg, eil, ea, eb, eop, ec, edv);
            run_instr(seq[i], 16'h3000, 1'b0, lat, tk, tg, il, oa, ob, oo, oc, od, d2, r2);
            n_tests++; if (lat !== elat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, elat); end
            case (i)
                2: begin
                    n_tests++; if (od !== 16'h0 || oc !== 3'b010) begin n_fail++; $display("FAIL sub_r4: got %h cond %b expected 0000 010", od, oc); end
                end
                3: begin
                    n_tests++; if (tk !== 1'b1 || tg !== 16'h2FFF || oc !== 3'b010 || oo !== 4'hF) begin
                        n_fail++; $display("FAIL br_z: got taken=%b tgt=%h cond=%b op=%h expected 1 2fff 010 f", tk, tg, oc, oo);
                    end
                end
                4: begin
                    n_tests++; if (tk !== 1'b0 || tg !== 16'h2FFF || oc !== 3'b010) begin
                        n_fail++; $display("FAIL br_np: got taken=%b tgt=%h cond=%b expected 0 2fff 010", tk, tg, oc);
                    end
                end
                5: begin
                    n_tests++; if (od !== 16'h0019 || oc !== 3'b001) begin n_fail++; $display("FAIL mul_r5: got %h cond %b expected 0019 001", od, oc); end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_illegal_hold();
        int lat, elat, acc0; logic tk, etk, il, eil, d2, r2;
        logic [15:0] tg, etg, oa, ea, ob, eb, od, edv; logic [3:0] oo, eop; logic [2:0] oc, ec;
        acc0 = n_accepts;
        ref_step(16'hB5C3, 16'h1234, elat, etk, etg, eil, ea, eb, eop, ec, edv);
        run_instr(16'hB5C3, 16'h1234, 1'b1, lat, tk, tg, il, oa, ob, oo, oc, od, d2, r2);
        n_tests++; if (lat !== 2 || il !== 1'b1 || tk !== 1'b0) begin
            n_fail++; $display("FAIL illegal_flag: got lat=%0d illegal=%b taken=%b expected 2 1 0", lat, il, tk);
        end
        n_tests++; if (oc !== ec || od !== edv) begin n_fail++; $display("FAIL illegal_state: got cond=%b r2=%h expected %b %h", oc, od, ec, edv); end
        repeat (3) @(negedge clk);
        n_tests++; if (n_accepts - acc0 !== 1 || done !== 1'b0 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL illegal_single_accept: got accepts=%0d done=%b illegal=%b expected 1 0 0", n_accepts - acc0, done, illegal);
        end
    endtask

    task automatic test_random();
        int lat, elat; logic tk, etk, il, eil, d2, r2;
        logic [15:0] tg, etg, oa, ea, ob, eb, od, edv; logic [3:0] oo, eop; logic [2:0] oc, ec;
        logic [15:0] ins, p; bit hold;
        for (int n = 0; n < 60; n++) begin
            ins  = 16'($urandom);
            p    = 16'($urandom);
            hold = ($urandom_range(0, 9) == 0);
            ref_step(ins, p, elat, etk, etg, eil, ea, eb, eop, ec, edv);
            run_instr(ins, p, hold, lat, tk, tg, il, oa, ob, oo, oc, od, d2, r2);
            n_tests++;
            if (lat !== elat || tk !== etk || tg !== etg || il !== eil || oc !== ec || od !== edv || oo !== eop ||
                (eop != 4'hF && (oa !== ea || ob !== eb)) || d2 !== 1'b0 || r2 !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d ins=%h: got lat=%0d tk=%b tg=%h il=%b cond=%b dv=%h op=%h a=%h b=%h d2=%b r2=%b expected lat=%0d tk=%b tg=%h il=%b cond=%b dv=%h op=%h a=%h b=%h d2=0 r2=1",
                         n, ins, lat, tk, tg, il, oc, od, oo, oa, ob, d2, r2, elat, etk, etg, eil, ec, edv, eop, ea, eb);
            end
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            n_tests++; if (dbg_data !== m_regs[i]) begin n_fail++; $display("FAIL sweep_reg%0d: got %h expected %h", i, dbg_data, m_regs[i]); end
        end
    endtask

    task automatic test_mid_reset();
        int dones, guard;
        @(negedge clk);
        guard = 0;
        while (!instr_ready && guard < 20) begin @(negedge clk); guard++; end
        // ADD R6, R0, #7
        instr = 16'h0C27; pc = 16'h0; instr_valid = 1'b1; dbg_addr = 3'd6;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (alu_op !== 4'h0) begin n_fail++; $display("FAIL midrst_in_exec: got op=%h expected 0", alu_op); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (instr_ready !== 1'b1 || alu_op !== 4'hF) begin
            n_fail++; $display("FAIL midrst_abort: got ready=%b op=%h expected 1 f", instr_ready, alu_op);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_tests++; if (dones !== 0 || dbg_data !== 16'h0 || cond_nzp !== 3'b010 || instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_result: got dones=%0d r6=%h cond=%b ready=%b expected 0 0000 010 1", dones, dbg_data, cond_nzp, instr_ready);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add_imm();
        test_sub_branch_mul();
        test_illegal_hold();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
